// File: rtl/nibble_des_pkg.sv
// Shared state encoding and counter width for the nibble deserializer.
package nibble_des_pkg;
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_PAR   = 2'd2;
  localparam state_t ST_HOLD  = 2'd3;
  localparam int     CNT_W    = 4;
endpackage

// File: rtl/nibble_shift_reg.sv
// WIDTH-bit serial-in shift register; MSB_FIRST picks which end the first bit ends up in.
module nibble_shift_reg #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] q_nxt;

  generate
    if (MSB_FIRST) begin : g_msb
      assign q_nxt = {q[WIDTH-2:0], din};
    end else begin : g_lsb
      assign q_nxt = {din, q[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset)         q <= '0;
    else if (shift_en) q <= q_nxt;
  end
endmodule

// File: rtl/nibble_deserializer.sv
// Serial-to-parallel front end for the 4-bit D register bank.
// Optional even-parity bit per word when NIBBLE_DES_PARITY_EN is defined.
module nibble_deserializer
  import nibble_des_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             serial_in,
  input  logic             serial_valid,
  output logic             serial_ready,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             out_ready,
  output logic             load_en,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             parity_err
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t state, state_nxt;
  logic   accept, shift_en, last_bit, par_ok;

  assign accept   = serial_valid & serial_ready;
  assign shift_en = accept & ((state == ST_IDLE) | (state == ST_SHIFT));
  assign last_bit = (bit_cnt == CNT_LAST);

  nibble_shift_reg #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_sreg (
    .clk      (CLK),
    .reset    (reset),
    .shift_en (shift_en),
    .din      (serial_in),
    .q        (word_out)
  );

  always_ff @(posedge CLK) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_SHIFT;
`ifdef NIBBLE_DES_PARITY_EN
      ST_SHIFT: if (accept && last_bit) state_nxt = ST_PAR;
      ST_PAR:   if (accept) state_nxt = par_ok ? ST_HOLD : ST_IDLE;
`else
      ST_SHIFT: if (accept && last_bit) state_nxt = ST_HOLD;
`endif
      ST_HOLD:  if (out_ready) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Reset gates the handshake outputs so nothing transfers during the reset cycle.
  always_comb begin
    serial_ready = 1'b0;
    word_valid   = 1'b0;
    if (state == ST_HOLD) word_valid   = 1'b1;
    else                  serial_ready = ~reset;
    load_en = word_valid & out_ready & ~reset;
  end

  always_ff @(posedge CLK) begin
    if (reset) bit_cnt <= '0;
    else begin
      case (state)
        ST_IDLE:  if (accept) bit_cnt <= CNT_W'(1);
        ST_SHIFT: if (accept) bit_cnt <= bit_cnt + CNT_W'(1);
        ST_PAR:   if (accept && !par_ok) bit_cnt <= '0;
        ST_HOLD:  if (out_ready) bit_cnt <= '0;
        default:  bit_cnt <= '0;
      endcase
    end
  end

`ifdef NIBBLE_DES_PARITY_EN
  logic par_acc, perr_q;

  assign par_ok     = ~(par_acc ^ serial_in);
  assign parity_err = perr_q;

  always_ff @(posedge CLK) begin
    if (reset) begin
      par_acc <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      perr_q <= (state == ST_PAR) & accept & ~par_ok;
      if (shift_en) par_acc <= (state == ST_IDLE) ? serial_in : (par_acc ^ serial_in);
    end
  end
`else
  assign par_ok     = 1'b1;
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_nibble_deserializer.sv
// Bench for nibble_deserializer: directed scenarios plus random traffic against a bit-queue model.
module tb_nibble_deserializer;
  localparam int WIDTH     = 4;
  localparam bit MSB_FIRST = 1'b1;
`ifdef NIBBLE_DES_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic             CLK, reset, serial_in, serial_valid, serial_ready;
  logic [WIDTH-1:0] word_out;
  logic             word_valid, out_ready, load_en, parity_err;
  logic [3:0]       bit_cnt;

  int errors = 0;
  int checks = 0;

  nibble_deserializer #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) dut (
    .CLK(CLK), .reset(reset), .serial_in(serial_in), .serial_valid(serial_valid),
    .serial_ready(serial_ready), .word_out(word_out), .word_valid(word_valid),
    .out_ready(out_ready), .load_en(load_en), .bit_cnt(bit_cnt), .parity_err(parity_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the word is just the list of accepted data bits; the hold flag says a word is waiting.
  bit         m_bits[$];
  bit         m_hold = 1'b0, m_perr = 1'b0, m_seen = 1'b0;
  logic [3:0] m_word = '0;

  function automatic logic [3:0] pack_bits();
    int v = 0;
    for (int i = 0; i < m_bits.size(); i++)
      v += int'(m_bits[i]) << (MSB_FIRST ? (WIDTH - 1 - i) : i);
    return 4'(v);
  endfunction

  function automatic bit xor_bits();
    int n = 0;
    foreach (m_bits[i]) n += int'(m_bits[i]);
    return bit'(n % 2);
  endfunction

  always @(negedge CLK) begin
    if (m_seen) begin
      chk("serial_ready", serial_ready, !reset && !m_hold);
      chk("word_valid",   word_valid,   m_hold);
      chk("load_en",      load_en,      m_hold && out_ready && !reset);
      chk("bit_cnt",      bit_cnt,      m_bits.size());
      chk("parity_err",   parity_err,   m_perr);
      if (m_hold) chk("word_out", word_out, m_word);
    end
    m_perr = 1'b0;
    if (reset) begin
      m_seen = 1'b1;
      m_hold = 1'b0;
      m_bits.delete();
    end else if (m_hold) begin
      if (out_ready) begin
        m_hold = 1'b0;
        m_bits.delete();
      end
    end else if (serial_valid) begin
      if (m_bits.size() < WIDTH) begin
        m_bits.push_back(serial_in);
        if (m_bits.size() == WIDTH && !PAR) begin
          m_hold = 1'b1;
          m_word = pack_bits();
        end
      end else if ((xor_bits() ^ serial_in) == 1'b0) begin
        m_hold = 1'b1;
        m_word = pack_bits();
      end else begin
        m_perr = 1'b1;
        m_bits.delete();
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_word(input logic [3:0] w, input int gap_after, input int gap_len, input bit flip);
    for (int i = 0; i < 4; i++) begin
      serial_valid = 1'b1;
      serial_in    = w[3-i];
      tick();
      if (i == gap_after) begin
        serial_valid = 1'b0;
        repeat (gap_len) begin
          #1 chk("gap_bit_cnt", bit_cnt, i + 1);
          tick();
        end
      end
    end
    if (PAR) begin
      serial_valid = 1'b1;
      serial_in    = (^w) ^ flip;
      tick();
    end
    serial_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; serial_valid = 1'b1; serial_in = 1'b1; out_ready = 1'b1;
    // T1: reset with traffic present
    tick(); tick();
    #1;
    chk("t1_load_en", load_en, 0);
    chk("t1_serial_ready", serial_ready, 0);
    chk("t1_word_valid", word_valid, 0);
    chk("t1_bit_cnt", bit_cnt, 0);
    chk("t1_word_out", word_out, 0);
    reset = 1'b0; serial_valid = 1'b0;
    #1 chk("t1_ready_after", serial_ready, 1);

    // T2: 1,0,1,1 with out_ready high
    out_ready = 1'b1;
    send_word(4'b1011, -1, 0, 1'b0);
    #1;
    chk("t2_word_valid", word_valid, 1);
    chk("t2_word_out", word_out, 4'b1011);
    chk("t2_load_en", load_en, 1);
    tick();
    #1 chk("t2_load_single", load_en, 0);

    // T3: backpressure
    out_ready = 1'b0;
    send_word(4'h6, -1, 0, 1'b0);
    repeat (5) begin
      #1;
      chk("t3_word_valid", word_valid, 1);
      chk("t3_serial_ready", serial_ready, 0);
      chk("t3_word_out", word_out, 4'h6);
      tick();
    end
    out_ready = 1'b1;
    #1 chk("t3_load_en", load_en, 1);
    tick();
    #1;
    chk("t3_ready_next", serial_ready, 1);
    chk("t3_load_single", load_en, 0);

    // T4: gap between bits 2 and 3
    send_word(4'h9, 1, 3, 1'b0);
    #1;
    chk("t4_word_out", word_out, 4'h9);
    chk("t4_word_valid", word_valid, 1);
    tick();

    // T5: reset mid-word, then a full word
    out_ready = 1'b0; serial_valid = 1'b1; serial_in = 1'b1;
    tick(); tick();
    reset = 1'b1; serial_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1 chk("t5_bit_cnt", bit_cnt, 0);
    out_ready = 1'b1;
    send_word(4'hC, -1, 0, 1'b0);
    #1;
    chk("t5_word_out", word_out, 4'hC);
    chk("t5_load_en", load_en, 1);
    tick();
    #1 chk("t5_load_single", load_en, 0);

`ifdef NIBBLE_DES_PARITY_EN
    // T6: good then bad parity
    send_word(4'b1010, -1, 0, 1'b0);
    #1;
    chk("t6_good_valid", word_valid, 1);
    chk("t6_good_word", word_out, 4'b1010);
    tick();
    send_word(4'b1010, -1, 0, 1'b1);
    #1;
    chk("t6_perr", parity_err, 1);
    chk("t6_no_valid", word_valid, 0);
    chk("t6_no_load", load_en, 0);
    tick();
    #1 chk("t6_perr_pulse", parity_err, 0);
`endif

    // Random traffic
    repeat (1500) begin
      reset        = ($urandom_range(0, 99) == 0);
      serial_valid = ($urandom_range(0, 9) < 7);
      serial_in    = 1'($urandom_range(0, 1));
      out_ready    = 1'($urandom_range(0, 1));
      tick();
    end
    reset = 1'b0; serial_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
